// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder slice and a carry flop iterated over WIDTH cycles.
// Define SERIAL_ADD_OVF_EN to add a registered signed-overflow output.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             bit_s, bit_c;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Full-adder slice on the current operand LSBs and stored carry.
  assign bit_s = a_q[0] ^ b_q[0] ^ c_q;
  assign bit_c = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {bit_s, res_q[WIDTH-1:1]};
        c_d   = bit_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = {bit_s, res_q[WIDTH-1:1]};
          cout_d  = bit_c;
`ifdef SERIAL_ADD_OVF_EN
          // c_q is the carry into the MSB while the last bit is processed.
          ovf_d   = c_q ^ bit_c;
`endif
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          a_d     = in_a;
          b_d     = in_b;
          c_d     = carry_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random additions
// compared against an arithmetic reference of a + b + carry_in.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] in_a, in_b;
  logic         carry_in;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         carry_out;
`ifdef SERIAL_ADD_OVF_EN
  logic         overflow;
`endif

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_sum  = '0;
  logic         exp_cout = 1'b0;
  logic         exp_ovf  = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_a      (in_a),
    .in_b      (in_b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer arithmetic on the captured operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] t;
    int         r;
    t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    exp_sum  = t[W-1:0];
    exp_cout = t[W];
    r = int'($signed(a)) + int'($signed(b)) + int'(cin);
    exp_ovf = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
  endtask

  task automatic chk_res(input string tag);
    chk({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    chk({tag, "_cout"}, 64'(carry_out), 64'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
`endif
  endtask

  // Called at a negedge with the DUT in IDLE or DONE; returns at the DONE negedge.
  // poke >= 0 raises start with 0x7F+0x7F during that SHIFT cycle, which must be ignored.
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int poke);
    start = 1'b1; in_a = a; in_b = b; carry_in = cin;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("busy_shift", 64'(busy), 64'd1);
      chk("done_early", 64'(done), 64'd0);
      chk_res("hold_shift");
      if (i == poke) begin
        start = 1'b1; in_a = 8'h7F; in_b = 8'h7F; carry_in = 1'b0;
      end else begin
        start = 1'b0; in_a = W'($urandom); in_b = W'($urandom); carry_in = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    model(a, b, cin);
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_in_done", 64'(busy), 64'd0);
    chk_res("result");
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk_res(tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_a = '0; in_b = '0; carry_in = 1'b0;
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("idle_after_reset");

    do_add(8'h3C, 8'h45, 1'b0, -1);
    chk("t1_sum_81", 64'(sum), 64'h81);
    @(negedge clk);
    chk_idle("idle_after_t1");

    do_add(8'hFF, 8'h01, 1'b0, -1);
    do_add(8'hFF, 8'hFF, 1'b1, -1);
    chk("t3_cout", 64'(carry_out), 64'd1);

    do_add(8'h10, 8'h20, 1'b0, 2);
    chk("ignored_start_sum", 64'(sum), 64'h30);
    repeat (3) begin
      @(negedge clk);
      chk_idle("no_second_op");
    end

    // Reset in the 4th SHIFT cycle of 0xAA+0x55.
    start = 1'b1; in_a = 8'hAA; in_b = 8'h55; carry_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    chk_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_idle("after_abort");
    end
    do_add(8'h01, 8'h02, 1'b0, -1);
    chk("post_reset_sum", 64'(sum), 64'h03);

    // start held high: one result every W+1 cycles.
    @(negedge clk);
    start = 1'b1; in_a = 8'h01; in_b = 8'h01; carry_in = 1'b0;
    for (int k = 0; k < 3 * (W + 1); k++) begin
      @(negedge clk);
      if (k == W) model(8'h01, 8'h01, 1'b0);
      chk("held_done", 64'(done), 64'((k % (W + 1)) == W));
      chk("held_busy", 64'(busy), 64'((k % (W + 1)) != W));
      chk_res("held");
    end
    start = 1'b0;
    @(negedge clk);
    chk_idle("held_release");

    for (int n = 0; n < 20; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk_idle("rand_gap");
      end
      do_add(W'($urandom), W'($urandom), 1'($urandom), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
